// File: rtl/data_memory.sv
// Line-wide (256-bit) data memory with a fixed multi-cycle access latency.
// An access is accepted from IDLE, counted through WAIT and completed with a
// one-cycle ack_o strobe; writes commit only at the ack edge.
// Optional build macro: DMEM_RDATA_GATE_EN gates data_o to zero outside ack.
module data_memory #(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH   = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o
);

  localparam int unsigned IdxW      = $clog2(DEPTH);
  localparam logic [5:0]  LastCount = 6'(LATENCY - 1);

  typedef enum logic {StIdle, StWait} state_t;

  state_t       state, state_next;
  logic [5:0]   count, count_next;
  logic [255:0] memory [DEPTH];

  logic [IdxW-1:0] line_idx;
  logic            unused_addr;

  // Byte offset within a line and bits above 16 KB do not select a line.
  assign line_idx    = addr_i[5 +: IdxW];
  assign unused_addr = ^{addr_i[31:5+IdxW], addr_i[4:0]};

  // Completion strobe decoded from the state and counter.
  assign ack_o = (state == StWait) && (count == LastCount);

  // State and counter registers; reset aborts any access in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= StIdle;
      count <= 6'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state logic: accept from IDLE, count through WAIT, return on ack.
  always_comb begin
    state_next = state;
    count_next = count;
    unique case (state)
      StIdle: begin
        if (enable_i) begin
          state_next = StWait;
          count_next = 6'd1;
        end else begin
          count_next = 6'd0;
        end
      end
      StWait: begin
        if (count == LastCount) begin
          state_next = StIdle;
          count_next = 6'd0;
        end else begin
          count_next = count + 6'd1;
        end
      end
      default: begin
        state_next = StIdle;
        count_next = 6'd0;
      end
    endcase
  end

  // Line write commits only on the ack edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (ack_o && write_i) begin
      memory[line_idx] <= data_i;
    end
  end

  // Combinational line read, optionally zeroed outside the ack cycle.
  always_comb begin
`ifdef DMEM_RDATA_GATE_EN
    data_o = ack_o ? memory[line_idx] : 256'b0;
`else
    data_o = memory[line_idx];
`endif
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory (default LATENCY=10, DEPTH=512).
// Read expectations are queued when a request is driven and popped at ack.
module tb_data_memory;

  localparam int unsigned Lat = 10;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         enable_i;
  logic         write_i;
  logic         ack_o;
  logic [255:0] data_o;

  logic [255:0] model [512];
  logic [255:0] exp_q [$];
  int           total = 0;
  int           bad   = 0;

  data_memory #(
    .LATENCY(Lat),
    .DEPTH  (512)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .enable_i(enable_i),
    .write_i (write_i),
    .ack_o   (ack_o),
    .data_o  (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete access, driven after a falling edge and sampled on falling edges.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [255:0] data,
                        input string tag);
    logic [8:0]   idx;
    logic [255:0] exp;
    logic [255:0] old;
    int           cycles;
    bit           seen;
    idx = addr[13:5];
    old = model[idx];
    if (!wr) exp_q.push_back(model[idx]);
    @(negedge clk_i);
    addr_i   = addr;
    data_i   = data;
    write_i  = wr;
    enable_i = 1'b1;
    cycles   = 0;
    seen     = 1'b0;
    while (!seen && cycles < 100) begin
      @(posedge clk_i);
      @(negedge clk_i);
      cycles++;
      if (ack_o) seen = 1'b1;
    end
    // ack is first visible in the cycle after edge LATENCY-1
    chk({tag, "_ack_cycle"}, 256'(cycles), 256'(Lat - 1));
    if (!wr) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 256'hx;
      chk({tag, "_rdata"}, data_o, exp);
    end else begin
      chk({tag, "_mem_before"}, dut.memory[idx], old);
    end
    @(posedge clk_i);
    #1 enable_i = 1'b0;
    @(negedge clk_i);
    chk({tag, "_ack_drop"}, 256'(ack_o), 256'd0);
    if (wr) begin
      model[idx] = data;
      chk({tag, "_mem_after"}, dut.memory[idx], data);
    end
  endtask

  initial begin
    int n_acks;
    int last_ack;
    bit prev_ack;

    rst_i    = 1'b1;
    addr_i   = 32'h0;
    data_i   = 256'h0;
    enable_i = 1'b0;
    write_i  = 1'b0;

    // Preload every line with a recognisable pattern, line 0 with 5.
    for (int i = 0; i < 512; i++) begin
      model[i]      = {8{i[31:0] ^ 32'hA5A5_0000}};
      dut.memory[i] = model[i];
    end
    model[0]      = 256'h5;
    dut.memory[0] = 256'h5;

    #1;
    chk("reset_ack", 256'(ack_o), 256'd0);
    chk("reset_count", 256'(dut.count), 256'd0);
    chk("reset_state", 256'(dut.state), 256'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Read of preloaded line 0.
    access(1'b0, 32'h0000_0000, 256'h0, "rd0");

    // Write line 1 then read it back.
    access(1'b1, 32'h0000_0020, 256'hDEADBEEF, "wr1");
    access(1'b0, 32'h0000_0020, 256'h0, "rd1");

    // Offset bits inside a line are ignored.
    access(1'b0, 32'h0000_003F, 256'h0, "rd1_off");

    // Idle read path behaviour.
    @(negedge clk_i);
    addr_i = 32'h0000_0020;
    #1;
`ifdef DMEM_RDATA_GATE_EN
    chk("idle_rdata", data_o, 256'b0);
`else
    chk("idle_rdata", data_o, model[1]);
`endif

    // Continuous enable: acks spaced LATENCY cycles apart, never adjacent.
    @(negedge clk_i);
    addr_i   = 32'h0;
    write_i  = 1'b0;
    enable_i = 1'b1;
    n_acks   = 0;
    last_ack = -1;
    prev_ack = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      chk("no_consec_ack", 256'(prev_ack & ack_o), 256'd0);
      if (ack_o) begin
        if (last_ack >= 0) chk("ack_spacing", 256'(c - last_ack), 256'(Lat));
        last_ack = c;
        n_acks++;
      end
      prev_ack = ack_o;
    end
    chk("ack_count", 256'(n_acks), 256'd4);
    enable_i = 1'b0;
    repeat (12) @(negedge clk_i);

    // Reset in WAIT cycle 5 of a write to line 32.
    @(negedge clk_i);
    addr_i   = 32'h0000_0400;
    data_i   = 256'hBAD0_BAD0;
    write_i  = 1'b1;
    enable_i = 1'b1;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    chk("pre_rst_count", 256'(dut.count), 256'd5);
    rst_i = 1'b1;
    #1;
    chk("rst_ack", 256'(ack_o), 256'd0);
    chk("rst_count", 256'(dut.count), 256'd0);
    chk("rst_state", 256'(dut.state), 256'd0);
    enable_i = 1'b0;
    @(negedge clk_i);
    rst_i  = 1'b0;
    n_acks = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk_i);
      if (ack_o) n_acks++;
    end
    chk("rst_no_ack", 256'(n_acks), 256'd0);
    chk("rst_mem32", dut.memory[32], model[32]);
    chk("rst_mem0_kept", dut.memory[0], 256'h5);

    // Address above 16 KB aliases line 1.
    access(1'b0, 32'h0000_4020, 256'h0, "alias");
    chk("alias_model", model[1], 256'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
